// File: rtl/flght_seq_pkg.sv
// Flight sequencer shared types and default timing constants.
// Optional watchdog build macro: FLGHT_SEQ_WDOG_EN.
package flght_seq_pkg;

  localparam int THRST_W = 9;

  localparam logic [23:0] CAL_CYCLES_DEF  = 24'd1000000;
  localparam logic [15:0] RAMP_DIV_DEF    = 16'd5000;
  localparam logic [23:0] WDOG_CYCLES_DEF = 24'd2500000;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CAL  = 3'd1,
    RAMP = 3'd2,
    FLY  = 3'd3,
    LAND = 3'd4
  } seq_state_t;

endpackage

// File: rtl/flght_tmr.sv
// Loadable down-counter; holds at zero, load beats enable.
// Used for calibration/ramp ticks and the command watchdog.
module flght_tmr #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] ld_val,
  output logic [W-1:0] val,
  output logic         zero
);

  // count down while enabled, never below zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val <= '0;
    end else if (load) begin
      val <= ld_val;
    end else if (en && (val != '0)) begin
      val <= val - 1'b1;
    end
  end

  assign zero = (val == '0);

endmodule

// File: rtl/flght_seq.sv
// Flight sequencer: arm/cal/ramp/fly/land control of mixer thrust.
// Optional command watchdog build macro: FLGHT_SEQ_WDOG_EN.
module flght_seq
  import flght_seq_pkg::*;
#(
  parameter logic [23:0] CAL_CYCLES  = CAL_CYCLES_DEF,
  parameter logic [15:0] RAMP_DIV    = RAMP_DIV_DEF,
  parameter logic [23:0] WDOG_CYCLES = WDOG_CYCLES_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         arm,
  input  logic         disarm,
  input  logic         cmd_vld,
  input  logic [8:0]   thrst_in,
  output logic         inertial_cal,
  output logic         motors_off,
  output logic [8:0]   thrst,
  output logic         flying,
  output logic [2:0]   seq_state
);

  localparam logic [23:0] CAL_M1 = CAL_CYCLES - 24'd1;
  localparam logic [23:0] DIV_M1 = {8'd0, RAMP_DIV - 16'd1};

  seq_state_t state;
  seq_state_t nxt;

  logic [THRST_W-1:0] nthr;
  logic               t_ld;
  logic [23:0]        t_val;
  logic               t_zero;
  logic [23:0]        cnt_unused;
  logic               t_en;
  logic               wd_exp;

  assign t_en = (state == CAL) || (state == RAMP) || (state == LAND);

  flght_tmr #(.W(24)) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (t_ld),
    .en     (t_en),
    .ld_val (t_val),
    .val    (cnt_unused),
    .zero   (t_zero)
  );

`ifdef FLGHT_SEQ_WDOG_EN
  logic        wd_ld;
  logic        wd_en;
  logic        wd_zero;
  logic [23:0] wd_val_unused;

  assign wd_ld = cmd_vld || ((state == CAL) && (nxt == RAMP));
  assign wd_en = (state == RAMP) || (state == FLY);

  flght_tmr #(.W(24)) u_wdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (wd_ld),
    .en     (wd_en),
    .ld_val (WDOG_CYCLES - 24'd1),
    .val    (wd_val_unused),
    .zero   (wd_zero)
  );

  assign wd_exp = wd_en && wd_zero && !cmd_vld;
`else
  logic        unused_cmd;
  logic [23:0] unused_wdog;

  assign unused_cmd  = cmd_vld;
  assign unused_wdog = WDOG_CYCLES;
  assign wd_exp      = 1'b0;
`endif

  // next state, next thrust and tick counter reloads
  always_comb begin
    nxt   = state;
    nthr  = thrst;
    t_ld  = 1'b0;
    t_val = DIV_M1;
    unique case (state)
      IDLE: begin
        nthr = '0;
        if (arm && !disarm) begin
          nxt   = CAL;
          t_ld  = 1'b1;
          t_val = CAL_M1;
        end
      end
      CAL: begin
        nthr = '0;
        if (disarm) begin
          nxt = IDLE;
        end else if (t_zero) begin
          nxt  = RAMP;
          t_ld = 1'b1;
        end
      end
      RAMP: begin
        if (disarm || wd_exp) begin
          nxt  = LAND;
          t_ld = 1'b1;
        end else if (thrst >= thrst_in) begin
          nthr = thrst_in;
          nxt  = FLY;
        end else if (t_zero) begin
          nthr = thrst + 9'd1;
          t_ld = 1'b1;
        end
      end
      FLY: begin
        if (disarm || wd_exp) begin
          nxt  = LAND;
          t_ld = 1'b1;
        end else begin
          nthr = thrst_in;
        end
      end
      LAND: begin
        if (thrst == '0) begin
          nxt = IDLE;
        end else if (t_zero) begin
          nthr = thrst - 9'd1;
          t_ld = 1'b1;
        end
      end
      default: begin
        nxt  = IDLE;
        nthr = '0;
      end
    endcase
  end

  // state and thrust registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      thrst <= '0;
    end else begin
      state <= nxt;
      thrst <= nthr;
    end
  end

  assign inertial_cal = (state == CAL);
  assign motors_off   = (state == IDLE);
  assign flying       = (state == FLY);
  assign seq_state    = state;

endmodule

// File: tb/tb_flght_seq.sv
// Directed self-checking bench for flght_seq.
// Short timing: CAL_CYCLES=16, RAMP_DIV=4, WDOG_CYCLES=64.
module tb_flght_seq;

  logic       clk;
  logic       rst_n;
  logic       arm;
  logic       disarm;
  logic       cmd_vld;
  logic [8:0] thrst_in;
  logic       inertial_cal;
  logic       motors_off;
  logic [8:0] thrst;
  logic       flying;
  logic [2:0] seq_state;

  int total;
  int bad;

  flght_seq #(
    .CAL_CYCLES  (24'd16),
    .RAMP_DIV    (16'd4),
    .WDOG_CYCLES (24'd64)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .arm          (arm),
    .disarm       (disarm),
    .cmd_vld      (cmd_vld),
    .thrst_in     (thrst_in),
    .inertial_cal (inertial_cal),
    .motors_off   (motors_off),
    .thrst        (thrst),
    .flying       (flying),
    .seq_state    (seq_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (seq_state != 3'd0 && n < 200) begin
      tick(1);
      n++;
    end
    chk(tag, {29'd0, seq_state}, 32'd0);
  endtask

  initial begin
    int n;
    total    = 0;
    bad      = 0;
    rst_n    = 1'b0;
    arm      = 1'b0;
    disarm   = 1'b0;
    cmd_vld  = 1'b1;
    thrst_in = 9'd10;
    tick(2);

    chk("rst_motors_off", {31'd0, motors_off}, 32'd1);
    chk("rst_thrst", {23'd0, thrst}, 32'd0);
    chk("rst_cal", {31'd0, inertial_cal}, 32'd0);
    chk("rst_flying", {31'd0, flying}, 32'd0);
    chk("rst_state", {29'd0, seq_state}, 32'd0);
    rst_n = 1'b1;
    tick(1);

    // 1: arm -> CAL for exactly 16 clks
    arm = 1'b1;
    chk("pre_arm_motors_off", {31'd0, motors_off}, 32'd1);
    tick(1);
    arm = 1'b0;
    chk("arm_motors_off", {31'd0, motors_off}, 32'd0);
    chk("arm_state_cal", {29'd0, seq_state}, 32'd1);
    n = 0;
    while (inertial_cal && n < 40) begin
      n++;
      tick(1);
    end
    chk("cal_len", n, 32'd16);
    chk("ramp_state", {29'd0, seq_state}, 32'd2);
    chk("ramp_thrst0", {23'd0, thrst}, 32'd0);

    // 2: ramp to 10, then follow thrst_in
    tick(3);
    chk("ramp_r3", {23'd0, thrst}, 32'd0);
    tick(1);
    chk("ramp_r4", {23'd0, thrst}, 32'd1);
    tick(36);
    chk("ramp_r40", {23'd0, thrst}, 32'd10);
    chk("ramp_r40_state", {29'd0, seq_state}, 32'd2);
    tick(1);
    chk("fly_state", {29'd0, seq_state}, 32'd3);
    chk("fly_flying", {31'd0, flying}, 32'd1);
    chk("fly_thrst", {23'd0, thrst}, 32'd10);
    thrst_in = 9'd200;
    chk("fly_lat0", {23'd0, thrst}, 32'd10);
    tick(1);
    chk("fly_lat1", {23'd0, thrst}, 32'd200);

    // 3: disarm with thrst=3, land 2,1,0; arm ignored
    thrst_in = 9'd3;
    tick(2);
    chk("fly_thrst3", {23'd0, thrst}, 32'd3);
    disarm = 1'b1;
    tick(1);
    disarm = 1'b0;
    chk("land_state", {29'd0, seq_state}, 32'd4);
    chk("land_l0", {23'd0, thrst}, 32'd3);
    arm = 1'b1;
    tick(1);
    arm = 1'b0;
    chk("land_arm_ign", {29'd0, seq_state}, 32'd4);
    tick(2);
    chk("land_l3", {23'd0, thrst}, 32'd3);
    tick(1);
    chk("land_l4", {23'd0, thrst}, 32'd2);
    tick(4);
    chk("land_l8", {23'd0, thrst}, 32'd1);
    tick(4);
    chk("land_l12", {23'd0, thrst}, 32'd0);
    chk("land_l12_state", {29'd0, seq_state}, 32'd4);
    tick(1);
    chk("land_idle", {29'd0, seq_state}, 32'd0);
    chk("land_motors_off", {31'd0, motors_off}, 32'd1);
    tick(3);
    chk("idle_stays", {29'd0, seq_state}, 32'd0);

    // 4: arm+disarm together, then disarm mid-CAL
    arm    = 1'b1;
    disarm = 1'b1;
    tick(1);
    arm    = 1'b0;
    disarm = 1'b0;
    chk("armdis_idle", {29'd0, seq_state}, 32'd0);
    arm = 1'b1;
    tick(1);
    arm = 1'b0;
    tick(10);
    chk("cal_cnt5_state", {29'd0, seq_state}, 32'd1);
    disarm = 1'b1;
    tick(1);
    disarm = 1'b0;
    chk("caldis_state", {29'd0, seq_state}, 32'd0);
    chk("caldis_cal", {31'd0, inertial_cal}, 32'd0);
    chk("caldis_motors_off", {31'd0, motors_off}, 32'd1);

    // 5: watchdog behaviour in FLY
    thrst_in = 9'd0;
    arm = 1'b1;
    tick(1);
    arm = 1'b0;
    tick(16);
    chk("wd_ramp", {29'd0, seq_state}, 32'd2);
    tick(1);
    chk("wd_fly0", {29'd0, seq_state}, 32'd3);
    chk("wd_fly0_thrst", {23'd0, thrst}, 32'd0);
    thrst_in = 9'd2;
    tick(1);
    chk("wd_fly_thrst2", {23'd0, thrst}, 32'd2);
    cmd_vld = 1'b0;
`ifdef FLGHT_SEQ_WDOG_EN
    tick(63);
    chk("wd_kick_c63", {29'd0, seq_state}, 32'd3);
    cmd_vld = 1'b1;
    tick(1);
    cmd_vld = 1'b0;
    chk("wd_kick_c64", {29'd0, seq_state}, 32'd3);
    tick(63);
    chk("wd_exp_c63", {29'd0, seq_state}, 32'd3);
    tick(1);
    chk("wd_exp_land", {29'd0, seq_state}, 32'd4);
`else
    tick(200);
    chk("nowd_fly", {29'd0, seq_state}, 32'd3);
    chk("nowd_flying", {31'd0, flying}, 32'd1);
    disarm = 1'b1;
    tick(1);
    disarm = 1'b0;
    chk("nowd_land", {29'd0, seq_state}, 32'd4);
`endif
    cmd_vld = 1'b1;
    wait_idle("wd_back_idle");

    // 6: async reset mid-RAMP, then full-scale ramp
    thrst_in = 9'h1FF;
    arm = 1'b1;
    tick(1);
    arm = 1'b0;
    tick(16);
    tick(10);
    chk("ar_thrst", {23'd0, thrst}, 32'd2);
    #3;
    rst_n = 1'b0;
    #1;
    chk("ar_motors_off", {31'd0, motors_off}, 32'd1);
    chk("ar_thrst0", {23'd0, thrst}, 32'd0);
    chk("ar_state", {29'd0, seq_state}, 32'd0);
    chk("ar_cal", {31'd0, inertial_cal}, 32'd0);
    rst_n = 1'b1;
    tick(1);
    chk("ar_hold_idle", {29'd0, seq_state}, 32'd0);

    arm = 1'b1;
    tick(1);
    arm = 1'b0;
    tick(16);
    chk("max_ramp", {29'd0, seq_state}, 32'd2);
    tick(2040);
    chk("max_r2040", {23'd0, thrst}, 32'h1FE);
    tick(4);
    chk("max_r2044", {23'd0, thrst}, 32'h1FF);
    chk("max_r2044_state", {29'd0, seq_state}, 32'd2);
    tick(1);
    chk("max_fly", {29'd0, seq_state}, 32'd3);
    tick(8);
    chk("max_nowrap", {23'd0, thrst}, 32'h1FF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
